multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control state machine for the multicycle RV32I core. Sequences the shared datapath (single memory port, single ALU, instruction/data registers) through fetch, decode, execute, memory and writeback steps. Drives the ALU operand selects and the 2-bit ALUOp class consumed by the ALU decoder, plus all register and memory write strobes. Supports lw, sw, R-type, I-type ALU, beq and jal, and stalls on a memory ready handshake.

## Interface
Parameters: none; all encodings are fixed.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state IDLE
- op  in  7  instruction opcode, from the instruction register (bits 6:0)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = register A
- ALUSrcB  out  2  00 = register B, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode from funct fields
- RegWrite  out  1  register file write enable
- IllegalOp  out  1  one-cycle pulse: unsupported opcode seen in DECODE
- InstrRetired  out  1  one-cycle pulse: last cycle of a legal instruction

## Operation
- Moore FSM. Outputs decode from the state register, except the gated strobes noted below. Any output not listed for a state is 0.
- PCWrite = PCUpdate | (Branch & zero). PCUpdate and Branch are internal signals.
- States, outputs and transitions:
  - IDLE: all outputs 0 → FETCH.
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate = mem_ready. Stays in FETCH while mem_ready=0; → DECODE when mem_ready=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precomputes the branch/jump target). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other op → FETCH, with IllegalOp=1 for this cycle.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. → MEMREAD if op=0000011, else → MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, InstrRetired=1. → FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for the whole stay. Holds until mem_ready=1; on that cycle InstrRetired=1, then → FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. → ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, InstrRetired=1. → FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, InstrRetired=1. → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. → ALUWB.
- op is sampled in DECODE and again in MEMADR. The instruction register is stable because IRWrite is 0 outside FETCH.

## Timing
- Reset: the state is IDLE immediately and asynchronously, and every output is 0. The first FETCH occurs in the second cycle after reset deasserts.
- Reset asserted mid-instruction aborts it with no further strobes. A MemWrite in progress drops the same cycle.
- Latency from FETCH entry to FETCH re-entry, with mem_ready=1 throughout:
  - lw 5 cycles; sw 4; R-type 4; I-type 4; beq 3; jal 4; illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. No strobe repeats while stalled: IRWrite/PCUpdate fire exactly once per fetch.
- mem_ready is ignored in every other state.
- IllegalOp and InstrRetired are never high in the same cycle.

## Test plan
- Reset: assert reset mid-MEMWRITE → MemWrite=0 in the same cycle, all outputs 0. Release reset → IDLE for 1 cycle, FETCH with IRWrite=1 on the next cycle (mem_ready=1).
- lw, op=0000011, mem_ready=1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 with ResultSrc=01 only in cycle 5; InstrRetired pulses once.
- sw with mem_ready held 0 for 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, then FETCH. With the same stall in FETCH, PCWrite pulses exactly once.
- beq: zero=1 → PCWrite=1 in the BEQ cycle. Repeat with zero=0 → PCWrite=0. Both cases use ALUOp=01 and 3-cycle latency.
- R-type (0110011), then I-type (0010011) → execute state drives ALUOp=10 with ALUSrcB=00 / 01 respectively; ALUWB asserts RegWrite with ResultSrc=00.
- jal (1101111) → JAL cycle has PCWrite=1, ALUSrcA=01, ALUSrcB=10, followed by ALUWB with RegWrite=1. Unknown op 1111111 → IllegalOp pulse in DECODE, FETCH next, no RegWrite/MemWrite.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the shared datapath.
// The controller takes the master side; the datapath takes the slave side.
interface multicycle_control_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       RegWrite;
  logic       IllegalOp;
  logic       InstrRetired;

  modport master (
    input  op, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
           RegWrite, IllegalOp, InstrRetired
  );

  modport slave (
    output op, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
           RegWrite, IllegalOp, InstrRetired
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over the shared datapath, stalling on the memory handshake.
module multicycle_control (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StFetch    = 4'd1;
  localparam logic [3:0] StDecode   = 4'd2;
  localparam logic [3:0] StMemAdr   = 4'd3;
  localparam logic [3:0] StMemRead  = 4'd4;
  localparam logic [3:0] StMemWb    = 4'd5;
  localparam logic [3:0] StMemWrite = 4'd6;
  localparam logic [3:0] StExecR    = 4'd7;
  localparam logic [3:0] StExecI    = 4'd8;
  localparam logic [3:0] StAluWb    = 4'd9;
  localparam logic [3:0] StBeq      = 4'd10;
  localparam logic [3:0] StJal      = 4'd11;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARegA  = 2'b10;
  localparam logic [1:0] SrcBRegB  = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;
  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluSub    = 2'b01;
  localparam logic [1:0] AluFunct  = 2'b10;
  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResData   = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;

  logic [3:0] state_q, state_d;
  logic       pc_update;
  logic       branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (bus.op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (bus.mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (bus.mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      default:    state_d = StIdle;
    endcase
  end

  // Stalled FETCH/MEMWRITE gate their strobes on mem_ready so they fire only once.
  always_comb begin
    pc_update        = 1'b0;
    branch           = 1'b0;
    bus.AdrSrc       = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.ResultSrc    = ResAluOut;
    bus.ALUSrcA      = SrcAPc;
    bus.ALUSrcB      = SrcBRegB;
    bus.ALUOp        = AluAdd;
    bus.RegWrite     = 1'b0;
    bus.IllegalOp    = 1'b0;
    bus.InstrRetired = 1'b0;
    case (state_q)
      StFetch: begin
        bus.ALUSrcA   = SrcAPc;
        bus.ALUSrcB   = SrcBFour;
        bus.ALUOp     = AluAdd;
        bus.ResultSrc = ResAluRes;
        bus.IRWrite   = bus.mem_ready;
        pc_update     = bus.mem_ready;
      end
      StDecode: begin
        bus.ALUSrcA = SrcAOldPc;
        bus.ALUSrcB = SrcBImm;
        bus.ALUOp   = AluAdd;
        case (bus.op)
          OpLoad, OpStore, OpRType, OpIType, OpBranch, OpJal: bus.IllegalOp = 1'b0;
          default:                                           bus.IllegalOp = 1'b1;
        endcase
      end
      StMemAdr: begin
        bus.ALUSrcA = SrcARegA;
        bus.ALUSrcB = SrcBImm;
        bus.ALUOp   = AluAdd;
      end
      StMemRead: begin
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = ResAluOut;
      end
      StMemWb: begin
        bus.ResultSrc    = ResData;
        bus.RegWrite     = 1'b1;
        bus.InstrRetired = 1'b1;
      end
      StMemWrite: begin
        bus.AdrSrc       = 1'b1;
        bus.ResultSrc    = ResAluOut;
        bus.MemWrite     = 1'b1;
        bus.InstrRetired = bus.mem_ready;
      end
      StExecR: begin
        bus.ALUSrcA = SrcARegA;
        bus.ALUSrcB = SrcBRegB;
        bus.ALUOp   = AluFunct;
      end
      StExecI: begin
        bus.ALUSrcA = SrcARegA;
        bus.ALUSrcB = SrcBImm;
        bus.ALUOp   = AluFunct;
      end
      StAluWb: begin
        bus.ResultSrc    = ResAluOut;
        bus.RegWrite     = 1'b1;
        bus.InstrRetired = 1'b1;
      end
      StBeq: begin
        bus.ALUSrcA      = SrcARegA;
        bus.ALUSrcB      = SrcBRegB;
        bus.ALUOp        = AluSub;
        bus.ResultSrc    = ResAluOut;
        branch           = 1'b1;
        bus.InstrRetired = 1'b1;
      end
      StJal: begin
        bus.ALUSrcA   = SrcAOldPc;
        bus.ALUSrcB   = SrcBFour;
        bus.ALUOp     = AluAdd;
        bus.ResultSrc = ResAluOut;
        pc_update     = 1'b1;
      end
      default: ;
    endcase
    bus.PCWrite = pc_update | (branch & bus.zero);
  end

  a_no_illegal_retire: assert property (@(posedge clk) disable iff (reset)
    !(bus.IllegalOp && bus.InstrRetired));

  a_no_write_collision: assert property (@(posedge clk) disable iff (reset)
    !(bus.MemWrite && bus.RegWrite));

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-instruction cycle plan built from the
// instruction class table is replayed with random stalls, and every cycle's outputs compared.
module tb_multicycle_control;

  logic clk;
  logic reset;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic        zr;
    logic [14:0] exp;
  } cyc_t;

  cyc_t plan[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cyc    = 0;

  logic [14:0] obs;
  assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.IllegalOp,
                bus.InstrRetired};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [14:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] aop, input logic rw, input logic ill,
                                     input logic ret);
    return {pcw, adr, mw, irw, rs, sa, sb, aop, rw, ill, ret};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [6:0] op, input logic mr, input logic zr,
                      input logic [14:0] exp);
    cyc_t c;
    c.op  = op;
    c.mr  = mr;
    c.zr  = zr;
    c.exp = exp;
    plan.push_back(c);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, from the instruction class table.
  task automatic plan_instr(input logic [6:0] op, input int sf, input int sm, input logic z);
    logic ill;
    ill = !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                       7'b1101111});
    for (int i = 0; i < sf; i++)
      push(7'($urandom), 1'b0, rbit(), mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0));
    push(7'($urandom), 1'b1, rbit(), mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0));
    push(op, rbit(), rbit(), mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, ill, 0));
    case (op)
      7'b0000011: begin
        push(op, rbit(), rbit(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0));
        for (int i = 0; i < sm; i++)
          push(op, 1'b0, rbit(), mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        push(op, 1'b1, rbit(), mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        push(op, rbit(), rbit(), mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 1));
      end
      7'b0100011: begin
        push(op, rbit(), rbit(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0));
        for (int i = 0; i < sm; i++)
          push(op, 1'b0, rbit(), mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        push(op, 1'b1, rbit(), mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1));
      end
      7'b0110011, 7'b0010011: begin
        push(op, rbit(), rbit(),
             mk(0, 0, 0, 0, 2'b00, 2'b10, (op == 7'b0010011) ? 2'b01 : 2'b00, 2'b10, 0, 0, 0));
        push(op, rbit(), rbit(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1));
      end
      7'b1100011:
        push(op, rbit(), z, mk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 1));
      7'b1101111: begin
        push(op, rbit(), rbit(), mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0));
        push(op, rbit(), rbit(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1));
      end
      default: ;
    endcase
  endtask

  task automatic run_plan(input int limit);
    int k;
    cyc_t c;
    k = 0;
    while (plan.size() > 0 && k < limit) begin
      c = plan.pop_front();
      bus.op        = c.op;
      bus.mem_ready = c.mr;
      bus.zero      = c.zr;
      @(negedge clk);
      check($sformatf("cyc%0d op=%b mr=%b z=%b", n_cyc, c.op, c.mr, c.zr), 32'(obs),
            32'(c.exp));
      @(posedge clk);
      #1;
      k++;
      n_cyc++;
    end
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] ops[7];
    logic [6:0] o;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
            7'b0000000};
    o = ops[$urandom_range(0, 6)];
    if (o == 7'b0000000) begin
      o = 7'($urandom);
      while (o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                       7'b1101111})
        o = 7'($urandom);
    end
    return o;
  endfunction

  initial begin
    clk           = 1'b0;
    reset         = 1'b1;
    bus.op        = 7'b0000011;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // IDLE then a directed pass over every instruction class.
    push(7'b0000011, 1'b1, 1'b1, 15'd0);
    plan_instr(7'b0000011, 0, 0, 1'b0);
    plan_instr(7'b0100011, 3, 3, 1'b0);
    plan_instr(7'b1100011, 0, 0, 1'b1);
    plan_instr(7'b1100011, 0, 0, 1'b0);
    plan_instr(7'b0110011, 0, 0, 1'b0);
    plan_instr(7'b0010011, 0, 0, 1'b0);
    plan_instr(7'b1101111, 0, 0, 1'b0);
    plan_instr(7'b1111111, 0, 0, 1'b0);
    run_plan(1000);

    // Abort a stalled store with an asynchronous reset.
    plan_instr(7'b0100011, 0, 5, 1'b0);
    run_plan(5);
    plan.delete();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("memwrite_before_reset", 32'(bus.MemWrite), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_outputs", 32'(obs), 32'd0);
    reset = 1'b0;
    push(7'b0000011, 1'b1, 1'b0, 15'd0);
    plan_instr(7'b0110011, 0, 0, 1'b0);
    run_plan(1000);

    for (int i = 0; i < 150; i++) begin
      plan_instr(rand_op(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, rbit());
      run_plan(1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
